ila_readout: RTL and testbench
==============================

ILA_READOUT -- requirements
Module: ila_readout

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the value bus and of each output word.
REQ-002 SHALL have parameter BUFFER_W, default 8, meaning width of the sample index and sample count.
REQ-003 SHALL have parameter SIGNAL_W, default 64, meaning width of one sample; N = ceil(SIGNAL_W/DATA_W) words per sample; SEL_W = max(1, clog2(N)).
REQ-004 SHALL have ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rst_soft  input  1  synchronous abort to IDLE, active-high.
- start  input  1  pulse requesting a full buffer dump.
- samples  input  BUFFER_W  number of valid samples in the ILA buffer.
- index  output  BUFFER_W  sample address driven to the ILA core.
- value_select  output  SEL_W  word-of-sample select driven to the ILA core.
- value  input  DATA_W  word returned by the ILA core.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts word.
- m_data  output  DATA_W  output word.
- m_last  output  1  final word of the dump.
- busy  output  1  dump in progress.
- done  output  1  one-cycle pulse at end of dump.

Function
REQ-005 SHALL implement FSM states IDLE, HEADER, FETCH, SEND, DONE.
REQ-006 IDLE: start=1 at edge k SHALL latch samples into cnt_q, clear index and value_select to 0, and enter HEADER (macro defined) or FETCH.
REQ-007 start while not IDLE SHALL be ignored.
REQ-008 FETCH SHALL last exactly one cycle; at its end, m_data <= value, m_valid <= 1, state <= SEND; value is valid one cycle after index/value_select.
REQ-009 SEND: on m_valid && m_ready, SHALL advance value_select; at N-1 wrap value_select to 0 and increment index; then FETCH, or DONE if the word was last.
REQ-010 Word order: sample 0 first; within a sample, value_select 0 (least-significant word) first.
REQ-011 m_data, m_last SHALL stay stable while m_valid && !m_ready; m_valid SHALL not drop before handshake.
REQ-012 m_last SHALL be 1 only on the final word (index = cnt_q-1, value_select = N-1, or header when cnt_q = 0).
REQ-013 DONE SHALL assert done for exactly one cycle and return to IDLE; busy = 1 in all states except IDLE.
REQ-014 cnt_q = 0 without header: SHALL go IDLE -> DONE directly, no m_valid beat.
REQ-015 Last sample word of a sample wider than DATA_W SHALL be zero-padded above SIGNAL_W mod DATA_W (pass value through unmodified; core pads).
REQ-016 Throughput: one word per two cycles at most, with m_ready held high.

Reset
REQ-017 rst=0 SHALL force state IDLE, index=0, value_select=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0, cnt_q=0 immediately.
REQ-018 rst_soft=1 at an edge SHALL apply the same values synchronously, overriding start and any pending handshake; no done pulse.

Configuration
REQ-019 Macro ILA_READOUT_HEADER_EN: defined -> HEADER state presents m_data = cnt_q zero-extended, m_valid=1, m_last=(cnt_q==0), then FETCH (or DONE if cnt_q=0) on handshake; undefined -> HEADER state absent, dump contains sample words only.

Verification
REQ-020 DATA_W=32, SIGNAL_W=64, samples=3, m_ready=1, no header: start -> 6 beats, index 0,0,1,1,2,2, value_select 0,1,0,1,0,1, m_last on 6th, done one cycle later.
REQ-021 Same, ILA_READOUT_HEADER_EN: first beat m_data=0x00000003, then 6 sample beats, 7 beats total.
REQ-022 Backpressure: m_ready=0 for 5 cycles mid-dump -> m_valid held, m_data unchanged, no word lost or duplicated.
REQ-023 samples=0: no header -> no beat, done 1 cycle after start; with header -> single beat 0x00000000 with m_last=1.
REQ-024 rst_soft pulse after 2nd beat -> m_valid=0, busy=0, index=0 next cycle; new start dumps from sample 0.
REQ-025 rst low asynchronously mid-SEND -> all outputs 0 before next clk edge; second start during busy ignored.

Source files
------------

// File: rtl/ila_readout.sv
// ila_readout: dumps an ILA sample buffer word-by-word onto a valid/ready stream.
// Define ILA_READOUT_HEADER_EN to prefix the dump with a sample-count header word.
module ila_readout #(
  parameter int DATA_W   = 32,
  parameter int BUFFER_W = 8,
  parameter int SIGNAL_W = 64,
  localparam int N       = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int SEL_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rst_soft,
  input  logic                start,
  input  logic [BUFFER_W-1:0] samples,
  output logic [BUFFER_W-1:0] index,
  output logic [SEL_W-1:0]    value_select,
  input  logic [DATA_W-1:0]   value,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_last,
  output logic                busy,
  output logic                done
);
  typedef enum logic [2:0] {IDLE, HEADER, FETCH, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [BUFFER_W-1:0] cnt_q, cnt_d, index_q, index_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, last_q, last_d;
  logic sel_last;
  assign sel_last = sel_q == SEL_W'(N - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (rst_soft) begin
      state_d = IDLE;
      cnt_d   = '0;
      index_d = '0;
      sel_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cnt_d   = samples;
          index_d = '0;
          sel_d   = '0;
`ifdef ILA_READOUT_HEADER_EN
          state_d = HEADER;
          data_d  = DATA_W'(samples);
          valid_d = 1'b1;
          last_d  = samples == '0;
`else
          state_d = (samples == '0) ? DONE : FETCH;
`endif
        end
        HEADER: if (m_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = (cnt_q == '0) ? DONE : FETCH;
        end
        // index/value_select were presented this cycle, so value is valid now
        FETCH: begin
          data_d  = value;
          valid_d = 1'b1;
          last_d  = (index_q == cnt_q - BUFFER_W'(1)) && sel_last;
          state_d = SEND;
        end
        SEND: if (m_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          sel_d   = sel_last ? '0 : sel_q + SEL_W'(1);
          index_d = sel_last ? index_q + BUFFER_W'(1) : index_q;
          state_d = last_q ? DONE : FETCH;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      index_q <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      index_q <= index_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  assign index        = index_q;
  assign value_select = sel_q;
  assign m_valid      = valid_q;
  assign m_data       = data_q;
  assign m_last       = last_q;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
endmodule

// File: tb/tb_ila_readout.sv
// tb_ila_readout: directed checks of ila_readout with a combinational ILA core model.
module tb_ila_readout;
  localparam int DW = 32, BW = 8, SW = 64;
`ifdef ILA_READOUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  logic clk = 0, rst = 0, rst_soft = 0, start = 0, m_ready = 1;
  logic [BW-1:0] samples = '0, index;
  logic [0:0] value_select;
  logic [DW-1:0] value, m_data;
  logic m_valid, m_last, busy, done;
  int nvec = 0, nerr = 0, cyc = 0, st_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [DW-1:0] bd[$];
  logic bl[$], bs[$];
  logic [BW-1:0] bi[$];
  int bc[$];
  always #5 clk = ~clk;
  assign value = {16'hA53C, index, 7'd0, value_select};
  ila_readout #(.DATA_W(DW), .BUFFER_W(BW), .SIGNAL_W(SW)) dut (
    .clk(clk), .rst(rst), .rst_soft(rst_soft), .start(start), .samples(samples),
    .index(index), .value_select(value_select), .value(value), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );
  always @(posedge clk) begin
    cyc++;
    if (rst && !rst_soft) begin
      if (m_valid && m_ready) begin
        bd.push_back(m_data);
        bl.push_back(m_last);
        bi.push_back(index);
        bs.push_back(value_select[0]);
        bc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end
  task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task clear;
    bd.delete(); bl.delete(); bi.delete(); bs.delete(); bc.delete();
    done_cnt = 0;
  endtask
  task do_start(input logic [BW-1:0] s);
    @(negedge clk);
    samples = s;
    start = 1;
    st_cyc = cyc + 1;
    @(negedge clk);
    start = 0;
    check("busy_after_start", busy, 1);
  endtask
  task wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check({tag, "_done_seen"}, k < 200, 1);
  endtask
  task wait_beats(input int n, input string tag);
    int k;
    k = 0;
    while (bd.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_beats_seen"}, k < 200, 1);
  endtask
  task check_dump(input int s, input bit spacing, input string tag);
    int total, k;
    logic [DW-1:0] e;
    total = HDR + 2 * s;
    check({tag, "_beats"}, bd.size(), total);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_end"}, busy, 0);
    if (bd.size() > 0) begin
      check({tag, "_done_lat"}, done_cyc - bc[bc.size()-1], 1);
      if (spacing) check({tag, "_first_lat"}, bc[0] - st_cyc, HDR ? 1 : 2);
    end else check({tag, "_done_lat"}, done_cyc - st_cyc, 1);
    for (int j = 0; j < bd.size() && j < total; j++) begin
      if (j < HDR) begin
        check($sformatf("%s_hdr_data", tag), bd[j], s);
        check($sformatf("%s_hdr_last", tag), bl[j], s == 0);
      end else begin
        k = j - HDR;
        e = 32'hA53C0000 | DW'((k / 2) << 8) | DW'(k % 2);
        check($sformatf("%s_data%0d", tag, j), bd[j], e);
        check($sformatf("%s_last%0d", tag, j), bl[j], k == 2 * s - 1);
        check($sformatf("%s_index%0d", tag, j), bi[j], k / 2);
        check($sformatf("%s_sel%0d", tag, j), bs[j], k % 2);
      end
      if (spacing && j > 0) check($sformatf("%s_gap%0d", tag, j), bc[j] - bc[j-1], 2);
    end
  endtask
  initial begin
    logic [DW-1:0] held;
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", index, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    @(negedge clk);
    rst = 1;
    clear();
    do_start(3);
    wait_done("s3");
    check_dump(3, 1, "s3");
    clear();
    do_start(0);
    wait_done("s0");
    check_dump(0, 1, "s0");
    clear();
    do_start(2);
    wait_beats(1, "bp");
    for (int k = 0; k < 20 && !m_valid; k++) @(negedge clk);
    check("bp_valid_pre", m_valid, 1);
    m_ready = 0;
    held = m_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_hold%0d", k), m_valid, 1);
      check($sformatf("bp_data_hold%0d", k), m_data, held);
    end
    m_ready = 1;
    wait_done("bp");
    check_dump(2, 0, "bp");
    clear();
    do_start(3);
    wait_beats(2, "soft");
    rst_soft = 1;
    @(negedge clk);
    rst_soft = 0;
    check("soft_valid", m_valid, 0);
    check("soft_busy", busy, 0);
    check("soft_index", index, 0);
    @(negedge clk);
    check("soft_no_done", done_cnt, 0);
    clear();
    do_start(3);
    wait_done("soft_re");
    check_dump(3, 1, "soft_re");
    clear();
    do_start(2);
    samples = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done("ign");
    check_dump(2, 0, "ign");
    clear();
    do_start(3);
    for (int k = 0; k < 20 && !m_valid; k++) @(negedge clk);
    check("ar_valid_pre", m_valid, 1);
    #2 rst = 0;
    #1;
    check("ar_valid", m_valid, 0);
    check("ar_data", m_data, 0);
    check("ar_last", m_last, 0);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_index", index, 0);
    check("ar_sel", value_select, 0);
    @(negedge clk);
    rst = 1;
    clear();
    do_start(1);
    wait_done("ar_re");
    check_dump(1, 1, "ar_re");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
